// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: preloads core data memory, holds/releases core reset, times the run.
// Optional build macro RUN_ABORT_EN: host dropping req during HOLD/RUN aborts the run to IDLE.
module cpu_run_ctrl #(
    parameter int unsigned CW      = 16,
    parameter int unsigned MAX_CYC = 60000,
    parameter int unsigned RST_CYC = 2,
    parameter int unsigned AW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_dat,
    output logic          ld_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dat,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    localparam int unsigned   HW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [HW-1:0] HoldLast = HW'(RST_CYC - 1);
    localparam logic [CW-1:0] CntLast  = CW'(MAX_CYC - 1);

    typedef enum logic [2:0] {StIdle, StHold, StRun, StDone, StFault} state_e;

    state_e        state_q, state_d;
    logic          req_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] cnt_d;
    logic          mem_wr_en_d;
    logic [AW-1:0] mem_addr_d;
    logic [7:0]    mem_dat_d;
    logic          start, accept, abort;

    assign start  = req & ~req_q;
    // ld_ready is only ever high while in IDLE, so it doubles as the accept qualifier
    assign accept = ld_valid & ld_ready;

`ifdef RUN_ABORT_EN
    assign abort = ~req;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cycle_cnt;
        mem_wr_en_d = accept;
        mem_addr_d  = accept ? ld_addr : mem_addr;
        mem_dat_d   = accept ? ld_dat : mem_dat;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHold;
                    hold_d  = '0;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (hold_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRun: begin
                // core_done has priority over the watchdog on the same cycle
                if (abort) begin
                    state_d = StIdle;
                end else if (core_done) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cycle_cnt + 1'b1;
                    if (cycle_cnt == CntLast) begin
                        state_d = StFault;
                    end
                end
            end
            StDone, StFault: begin
                if (!req_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they are pure Moore outputs of state_q.
    always_ff @(posedge clk) begin
        req_q <= req;
        if (reset) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            cycle_cnt  <= '0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_dat    <= '0;
            ld_ready   <= 1'b1;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cycle_cnt  <= cnt_d;
            mem_wr_en  <= mem_wr_en_d;
            mem_addr   <= mem_addr_d;
            mem_dat    <= mem_dat_d;
            ld_ready   <= (state_d == StIdle);
            core_reset <= (state_d != StRun);
            busy       <= (state_d == StHold) || (state_d == StRun);
            done       <= (state_d == StDone) || (state_d == StFault);
            timeout    <= (state_d == StFault);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized self-checking bench for cpu_run_ctrl against a behavioural run/preload model.
module tb_cpu_run_ctrl;

    localparam int unsigned CW      = 16;
    localparam int unsigned MAX_CYC = 100;
    localparam int unsigned RST_CYC = 2;
    localparam int unsigned AW      = 8;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          req       = 1'b0;
    logic          ld_valid  = 1'b0;
    logic [AW-1:0] ld_addr   = '0;
    logic [7:0]    ld_dat    = '0;
    logic          core_done = 1'b0;
    logic          ld_ready, mem_wr_en, core_reset, busy, done, timeout;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dat;
    logic [CW-1:0] cycle_cnt;

    cpu_run_ctrl #(
        .CW     (CW),
        .MAX_CYC(MAX_CYC),
        .RST_CYC(RST_CYC),
        .AW     (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_dat    (ld_dat),
        .ld_ready  (ld_ready),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_dat   (mem_dat),
        .core_reset(core_reset),
        .core_done (core_done),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: remaining hold cycles, running flag, finished flag, watchdog flag, run count.
    bit m_req_q    = 1'b0;
    int m_hold_left = 0;
    bit m_run      = 1'b0;
    bit m_fin      = 1'b0;
    bit m_to       = 1'b0;
    int m_cnt      = 0;
    bit m_wr       = 1'b0;
    int m_addr     = 0;
    int m_dat      = 0;

    function automatic bit m_idle();
        return (m_hold_left == 0) && !m_run && !m_fin;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_update();
        bit acc, start, abort_now;
        if (reset) begin
            m_hold_left = 0;
            m_run = 0; m_fin = 0; m_to = 0;
            m_cnt = 0; m_wr = 0; m_addr = 0; m_dat = 0;
            m_req_q = req;
            return;
        end
`ifdef RUN_ABORT_EN
        abort_now = !req;
`else
        abort_now = 1'b0;
`endif
        acc   = ld_valid && m_idle();
        start = req && !m_req_q;
        if (m_idle()) begin
            if (start) begin
                m_hold_left = RST_CYC;
                m_cnt = 0;
            end
        end else if (m_hold_left > 0) begin
            if (abort_now) begin
                m_hold_left = 0;
            end else begin
                m_hold_left--;
                if (m_hold_left == 0) m_run = 1;
            end
        end else if (m_run) begin
            if (abort_now) begin
                m_run = 0;
            end else if (core_done) begin
                m_run = 0;
                m_fin = 1;
            end else begin
                m_cnt++;
                if (m_cnt == MAX_CYC) begin
                    m_run = 0; m_fin = 1; m_to = 1;
                end
            end
        end else if (!m_req_q) begin
            m_fin = 0;
            m_to = 0;
        end
        m_wr = acc;
        if (acc) begin
            m_addr = ld_addr;
            m_dat  = ld_dat;
        end
        m_req_q = req;
    endtask

    task automatic check_all();
        check_val("core_reset", core_reset, !m_run);
        check_val("ld_ready", ld_ready, m_idle());
        check_val("busy", busy, (m_hold_left > 0) || m_run);
        check_val("done", done, m_fin);
        check_val("timeout", timeout, m_to);
        check_val("cycle_cnt", cycle_cnt, m_cnt);
        check_val("mem_wr_en", mem_wr_en, m_wr);
        check_val("mem_addr", mem_addr, m_addr);
        check_val("mem_dat", mem_dat, m_dat);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    // Keep req high, raise core_done on RUN cycle n_done (0 = never), stop once finished.
    task automatic run_until(input int n_done, output int hold_seen);
        int k = 0;
        hold_seen = 0;
        req = 1'b1;
        for (int i = 0; i < 400 && !m_fin; i++) begin
            if (m_run) begin
                k++;
                core_done = (n_done > 0) && (k >= n_done);
            end else begin
                core_done = 1'b0;
            end
            step();
            if (busy && core_reset) hold_seen++;
        end
        core_done = 1'b0;
        check_val("run_done", done, 1);
    endtask

    task automatic release_req();
        req = 1'b0;
        repeat (3) step();
        check_val("rel_done", done, 0);
        check_val("rel_ld_ready", ld_ready, 1);
    endtask

    initial begin
        int hs;
        int pct_tab[6] = '{0, 5, 20, 100, 300, 1000};

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_val("rst_core_reset", core_reset, 1);
        check_val("rst_ld_ready", ld_ready, 1);
        check_val("rst_cnt", cycle_cnt, 0);

        ld_valid = 1'b1; ld_addr = 8'h10; ld_dat = 8'hA5;
        step();
        check_val("beat0_addr", mem_addr, 8'h10);
        ld_addr = 8'h11; ld_dat = 8'h3C;
        step();
        check_val("beat1_dat", mem_dat, 8'h3C);
        ld_valid = 1'b0; req = 1'b1;
        step();
        check_val("start_ld_ready", ld_ready, 0);
        ld_valid = 1'b1; ld_addr = 8'h55;
        step();
        check_val("hold_no_write", mem_wr_en, 0);
        ld_valid = 1'b0;

        run_until(38, hs);
        check_val("done38_cnt", cycle_cnt, 37);
        check_val("done38_to", timeout, 0);
        check_val("done38_crst", core_reset, 1);
        release_req();

        run_until(0, hs);
        check_val("hold_len", hs, RST_CYC);
        check_val("wd_to", timeout, 1);
        check_val("wd_cnt", cycle_cnt, MAX_CYC);
        release_req();
        run_until(MAX_CYC, hs);
        check_val("wd_tie_to", timeout, 0);
        check_val("wd_tie_cnt", cycle_cnt, MAX_CYC - 1);
        release_req();

        req = 1'b1;
        for (int i = 0; i < 100 && !(m_run && m_cnt == 20); i++) step();
        check_val("mid_cnt20", cycle_cnt, 20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_cnt", cycle_cnt, 0);
        repeat (10) step();
        check_val("no_restart", busy, 0);
        req = 1'b0;
        step();
        req = 1'b1;
        step();
        check_val("restart", busy, 1);

        for (int i = 0; i < 100 && !(m_run && m_cnt == 5); i++) step();
        req = 1'b0;
        repeat (3) step();
`ifdef RUN_ABORT_EN
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_cnt", cycle_cnt, 5);
`else
        check_val("noabort_busy", busy, 1);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        check_val("noabort_done", done, 1);
`endif
        repeat (3) step();

        for (int e = 0; e < 6; e++) begin
            for (int c = 0; c < 500; c++) begin
                reset     = ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 19) == 0) req = ~req;
                ld_valid  = $urandom_range(0, 1) == 1;
                ld_addr   = AW'($urandom);
                ld_dat    = 8'($urandom);
                core_done = $urandom_range(0, 999) < pct_tab[e];
                step();
            end
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Host-side run controller directly upstream of the single-cycle core (top_level). It preloads core data memory through a valid/ready port and holds the core in reset while doing so. It then releases the core on a host req edge and counts run cycles until the core's done, or until a watchdog timeout. Results go back to the host on a four-phase req/done handshake.

Parameters:
CW, 16, cycle counter width
MAX_CYC, 60000, watchdog limit in RUN cycles (1 ≤ MAX_CYC ≤ 2^CW-1)
RST_CYC, 2, cycles core_reset is held after start before RUN (≥1)
AW, 8, preload address width

Ports:
clk  in  1  clock, all logic posedge
reset  in  1  synchronous, active-high
req  in  1  host start request (level, 4-phase)
ld_valid  in  1  preload beat valid
ld_addr  in  AW  preload address
ld_dat  in  8  preload data
ld_ready  out  1  preload beat accepted when ld_valid&ld_ready
mem_wr_en  out  1  write strobe to core data memory
mem_addr  out  AW  write address
mem_dat  out  8  write data
core_reset  out  1  reset to core
core_done  in  1  core done flag
busy  out  1  core running
done  out  1  run finished (normal or timeout)
timeout  out  1  run ended by watchdog
cycle_cnt  out  CW  RUN cycles counted

Behaviour:
- All outputs registered (Moore, from state/regs). Reset value: state IDLE, core_reset=1, ld_ready=1 on the cycle after reset, busy=0, done=0, timeout=0, cycle_cnt=0, mem_wr_en=0, mem_addr=0, mem_dat=0.
- States: IDLE, HOLD, RUN, DONE, FAULT. req_q is the registered req; start = req & ~req_q.
- IDLE: core_reset=1, ld_ready=1. An accepted beat gives mem_wr_en=1 with mem_addr/mem_dat = beat values on the next cycle (1-cycle latency); otherwise mem_wr_en=0. On start, go to HOLD. A beat accepted in the same cycle as start is still written. The core is in reset, so this is safe.
- HOLD: ld_ready=0, core_reset=1, busy=1, cycle_cnt cleared on entry. Stay exactly RST_CYC cycles, then go to RUN. core_done is ignored.
- RUN: core_reset=0, busy=1. Each cycle with core_done=0, cycle_cnt increments.
  - core_done=1: go to DONE; cycle_cnt holds.
  - cycle_cnt==MAX_CYC-1 and core_done=0: go to FAULT with cycle_cnt=MAX_CYC.
  - Both on the same cycle: core_done wins; timeout stays 0.
- DONE: done=1, busy=0, core_reset=1 (freezes core; data memory untouched), cycle_cnt held. When req_q=0, go to IDLE; done=0 on the next cycle.
- FAULT: same as DONE plus timeout=1. timeout clears on the same edge as done.
- req falling during HOLD/RUN: ignored (see optional feature). If req is already low at completion, DONE/FAULT lasts exactly one cycle.
- req held high after returning to IDLE: no restart until req falls and rises again.
- reset at any state: IDLE on the next edge, core_reset=1, pending write dropped (mem_wr_en=0).
- ld_valid outside IDLE: not accepted, no write.

Optional Feature:
RUN_ABORT_EN
- Defined: req=0 sampled in HOLD or RUN aborts the run. Next state is IDLE with core_reset=1, done=0, timeout=0, busy=0; cycle_cnt keeps its last value.
- Undefined: req deassertion during HOLD/RUN is ignored, as described above.

Test Plan:
1. Reset held 3 cycles, then released -> core_reset=1, ld_ready=1, busy=0, done=0, timeout=0, cycle_cnt=0, mem_wr_en=0.
2. Beats (0x10,0xA5) then (0x11,0x3C) on consecutive cycles -> mem_wr_en=1 with the same values one cycle later each. req rises -> ld_ready=0 next cycle; a beat offered afterwards produces no write.
3. RST_CYC=2: req=1 -> core_reset high 2 cycles then low. core_done first high on RUN cycle 38 -> done=1, cycle_cnt=37, core_reset=1, timeout=0. req=0 -> done=0 one cycle later, state IDLE.
4. MAX_CYC=100, core_done held 0 -> timeout=1, done=1, cycle_cnt=100 after 100 RUN cycles. Repeat with core_done=1 on RUN cycle 100 -> timeout=0, cycle_cnt=99.
5. reset pulsed mid-RUN at cycle_cnt=20 -> next cycle IDLE, core_reset=1, busy=0, cycle_cnt=0. req held high produces no restart until toggled low then high.
6. RUN_ABORT_EN defined: req dropped at cycle_cnt=5 -> IDLE, done never asserted, cycle_cnt=5. Undefined: run continues to core_done.
